b3_serial_sub: RTL
==================

# b3_serial_sub

Digit-serial base-3 subtractor. It computes X − Y for two N-digit ternary operands, one digit per clock, least-significant digit first. Each digit is encoded in 2 bits: 00=0, 01=1, 10=2, 11=invalid. It is the inverse datapath of the combinational base-3 digit adder and shares its digit encoding. It sits beside that adder in the ternary arithmetic unit and provides a start/done handshake to the controlling FSM.

## Interface
- N, 4, number of ternary digits per operand (N ≥ 2)
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- x  in  2N  minuend, digit k at bits [2k+1:2k]
- y  in  2N  subtrahend, same layout
- ready  out  1  block idle, start will be accepted
- done  out  1  one-cycle pulse, d/bout/err valid
- d  out  2N  difference digits, same layout
- bout  out  1  final borrow; 1 ⇔ X < Y (d then holds 3^N + X − Y)
- err  out  1  at least one operand digit was encoded 11

## Operation
- Reset values: ready=1, done=0, d=0, bout=0, err=0, state IDLE, digit counter 0, borrow register 0.
- States:
  - IDLE: ready=1. start=1 at an edge latches x and y into internal shift registers, clears borrow, counter and the internal err flag, and moves to RUN.
  - RUN: ready=0. Each edge processes the current low digit pair and increments the counter. After digit N−1, the state returns to IDLE.
- Digit rule, applied to xk, yk and borrow-in b:
  - t = xk − yk − b
  - t ≥ 0 → dk = t, borrow-out 0
  - t < 0 → dk = t + 3, borrow-out 1
  - The borrow register carries borrow-out to digit k+1.
- Invalid digit (xk or yk = 11): dk = 00, borrow passes through unchanged, internal err flag set (sticky for the operation).
- Completion edge (digit N−1 processed):
  - d ← assembled result, bout ← final borrow, err ← internal flag.
  - done=1 for exactly the following cycle.
  - d, bout and err hold until the next completion or reset.
- d, bout and err never change while in RUN.
- start while ready=0 is ignored, with no queuing.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Accept edge t0: state RUN from t0; ready=0 in the cycle after t0.
- Digit k is processed on edge t0+1+k.
- Completion edge is t0+N. In the cycle after t0+N: done=1 and ready=1.
- Latency: start edge to done-high is N cycles. Throughput: one operation per N cycles.
- start=1 during the done cycle is accepted on that edge:
  - done falls, ready falls, and the new operation runs.
  - The previous d/bout/err remain held until the new completion.
- reset=1 on any edge, including mid-RUN, forces all reset values at that edge. The aborted operation never raises done. reset has priority over start.

## Structure
- Shared header b3_defs.vh holds the digit codes B3_ZERO=2'b00, B3_ONE=2'b01, B3_TWO=2'b10, B3_INV=2'b11 and the state codes. The adder uses the same header.
- Sub-module b3_digit_sub is combinational: inputs x, y (2 bits each) and bin; outputs d (2 bits), bout, inv. It implements the digit rule above and is instantiated once.
- Top level contains:
  - FSM
  - counter, $clog2(N) bits
  - x/y shift registers, shifting right 2 bits per RUN edge
  - result shift register, filling from the top
  - borrow register
  - output registers

## Test plan (N=4)
- x=01_10_01_00 (1210₃=48), y=00_01_00_10 (0102₃=11), start one cycle → exactly 4 cycles later done=1, d=01_01_00_01 (1101₃=37), bout=0, err=0.
- x=0, y=00_00_00_01 → d=10_10_10_10 (2222₃), bout=1. Borrow ripples through all digits.
- x=y=10_10_10_10 → d=0, bout=0. Additionally, x=y=0 → d=0, bout=0.
- x=00_00_11_01, y=0 → done after 4 cycles with err=1 and digit 1 of d = 00. A following clean operation → err=0.
- start at t0, start pulsed again at t0+2, reset=1 at t0+3 → no done ever appears; ready=1, d=0, bout=0 after the reset edge.
- Back-to-back: second start held high during the done cycle → second done exactly 4 cycles later. The first result stays held on d in between.

Source files
------------

// File: rtl/b3_serial_sub_pkg.sv
// Shared definitions for the ternary arithmetic unit: digit codes, FSM states,
// and a helper for spotting the invalid digit encoding.
package b3_serial_sub_pkg;

  localparam logic [1:0] B3_ZERO = 2'b00;
  localparam logic [1:0] B3_ONE  = 2'b01;
  localparam logic [1:0] B3_TWO  = 2'b10;
  localparam logic [1:0] B3_INV  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic b3_is_inv(input logic [1:0] dig);
    return dig == B3_INV;
  endfunction

endpackage

// File: rtl/b3_serial_sub_digit_sub.sv
// Combinational single-digit ternary subtractor: d = x - y - bin (mod 3) with
// borrow-out; an invalid operand digit yields 0 and passes the borrow through.
module b3_digit_sub
  import b3_serial_sub_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       bin,
  output logic [1:0] d,
  output logic       bout,
  output logic       inv
);

  logic signed [3:0] t;
  logic signed [3:0] t_wrap;

  always_comb begin
    t      = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({3'b000, bin});
    t_wrap = t + 4'sd3;
    inv    = b3_is_inv(x) || b3_is_inv(y);
    d      = B3_ZERO;
    bout   = 1'b0;
    if (inv) begin
      bout = bin;
    end else if (t < 0) begin
      d    = t_wrap[1:0];
      bout = 1'b1;
    end else begin
      d    = t[1:0];
    end
  end

endmodule

// File: rtl/b3_serial_sub.sv
// Digit-serial base-3 subtractor X - Y, one digit per clock, LSD first, with a
// start/ready/done handshake; results are held until the next completion.
module b3_serial_sub
  import b3_serial_sub_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] x,
  input  logic [2*N-1:0] y,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] d,
  output logic           bout,
  output logic           err
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] xs_q, xs_d, ys_q, ys_d, res_q, res_d;
  logic           brw_q, brw_d, eacc_q, eacc_d;
  logic [2*N-1:0] d_q, d_d;
  logic           bout_q, bout_d, err_q, err_d, done_q, done_d;

  logic [1:0] dig;
  logic       dig_bout, dig_inv;

  b3_digit_sub u_digit (
    .x    (xs_q[1:0]),
    .y    (ys_q[1:0]),
    .bin  (brw_q),
    .d    (dig),
    .bout (dig_bout),
    .inv  (dig_inv)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    res_d   = res_q;
    brw_d   = brw_q;
    eacc_d  = eacc_q;
    d_d     = d_q;
    bout_d  = bout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          xs_d    = x;
          ys_d    = y;
          brw_d   = 1'b0;
          cnt_d   = '0;
          eacc_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Result fills from the top so digit 0 lands at the bottom after N shifts.
        xs_d   = {2'b00, xs_q[2*N-1:2]};
        ys_d   = {2'b00, ys_q[2*N-1:2]};
        res_d  = {dig, res_q[2*N-1:2]};
        brw_d  = dig_bout;
        eacc_d = eacc_q | dig_inv;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          d_d     = {dig, res_q[2*N-1:2]};
          bout_d  = dig_bout;
          err_d   = eacc_q | dig_inv;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      eacc_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      eacc_q  <= eacc_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Operand and partial-result shift registers are pure data; no reset needed.
  always_ff @(posedge clock) begin
    xs_q  <= xs_d;
    ys_q  <= ys_d;
    res_q <= res_d;
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign d     = d_q;
  assign bout  = bout_q;
  assign err   = err_q;

endmodule
